// File: rtl/mul_div_unit_if.sv
// Start/busy/done handshake and result bus of the iterative multiply/divide unit.
// The master launches operations; the unit (slave) returns results and flags.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Long;
  logic [3:0]       Flags;

  modport master (
    output start, Op, a, b,
    input  busy, done, Result, Long, Flags
  );

  modport slave (
    input  start, Op, a, b,
    output busy, done, Result, Long, Flags
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative one-bit-per-cycle multiplier / restoring divider for the execute stage.
// Signed ops run on magnitudes; the sign is fixed up when the last iteration retires.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_UMULL = 3'd1;
  localparam logic [2:0] OP_SMULL = 3'd2;
  localparam logic [2:0] OP_UDIV  = 3'd3;
  localparam logic [2:0] OP_SDIV  = 3'd4;

  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]       r_op;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mc;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_long;
  logic [3:0]       r_flags;

  logic             w_accept;
  logic             w_is_div;
  logic             w_rsv;
  logic             w_dz;
  logic             w_ovf;
  logic             w_short;
  logic             w_sgn;
  logic [WIDTH-1:0] w_a0;
  logic [WIDTH-1:0] w_b0;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign w_accept = bus.start && (r_state != S_CALC);
  assign w_is_div = (bus.Op == OP_UDIV) ||
                    (bus.Op == OP_SDIV);
  assign w_rsv    = bus.Op > OP_SDIV;
  assign w_dz     = w_is_div && (bus.b == '0);
  assign w_ovf    = (bus.Op == OP_SDIV) &&
                    (bus.a == MIN_NEG) &&
                    (bus.b == '1);
  assign w_short  = w_rsv | w_dz | w_ovf;

  always_comb begin
    w_sgn = (bus.Op == OP_SMULL) ||
            (bus.Op == OP_SDIV);
    w_a0  = w_sgn ? mag(bus.a) : bus.a;
    w_b0  = w_sgn ? mag(bus.b) : bus.b;
  end

  logic             w_mul_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_hi_n;
  logic [WIDTH-1:0] w_lo_n;

  assign w_mul_op = r_op < OP_UDIV;

  // Multiply shifts right through {hi,lo}; divide shifts left.
  always_comb begin
    w_sum  = {1'b0, r_hi} +
             (r_lo[0] ? {1'b0, r_mc} : '0);
    w_sh   = {r_hi, r_lo[WIDTH-1]};
    w_diff = w_sh - {1'b0, r_mc};
    if (w_mul_op) begin
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_hi_n = w_diff[WIDTH] ? w_sh[WIDTH-1:0]
                             : w_diff[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end
  end

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fres;
  logic [WIDTH-1:0]   w_flong;
  logic [3:0]         w_fflags;
  logic               w_long_n;

  always_comb begin
    w_prod  = r_neg_q ? -{w_hi_n, w_lo_n}
                      : {w_hi_n, w_lo_n};
    w_fres  = '0;
    w_flong = '0;
    case (r_op)
      OP_MUL: begin
        w_fres = w_prod[WIDTH-1:0];
      end
      OP_UMULL, OP_SMULL: begin
        w_fres  = w_prod[WIDTH-1:0];
        w_flong = w_prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        w_fres  = r_neg_q ? -w_lo_n : w_lo_n;
        w_flong = r_neg_r ? -w_hi_n : w_hi_n;
      end
    endcase
    w_long_n = (r_op == OP_UMULL) ||
               (r_op == OP_SMULL);
    w_fflags = 4'b0000;
    w_fflags[3] = w_long_n ? w_flong[WIDTH-1]
                           : w_fres[WIDTH-1];
    w_fflags[2] = (w_fres == '0) &&
                  (!w_long_n || (w_flong == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (w_accept) begin
          w_next = w_short ? S_FIN : S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_count == CW'(1)) begin
          w_next = S_FIN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Short-circuit results are written on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= '0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mc    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_res   <= '0;
      r_long  <= '0;
      r_flags <= '0;
    end else if (w_accept) begin
      r_op    <= bus.Op;
      r_count <= CW'(WIDTH);
      r_hi    <= '0;
      r_neg_q <= w_sgn & (bus.a[WIDTH-1] ^
                          bus.b[WIDTH-1]);
      r_neg_r <= (bus.Op == OP_SDIV) &
                 bus.a[WIDTH-1];
      if (w_is_div) begin
        r_mc <= w_b0;
        r_lo <= w_a0;
      end else begin
        r_mc <= w_a0;
        r_lo <= w_b0;
      end
      if (w_rsv) begin
        r_res   <= '0;
        r_long  <= '0;
        r_flags <= 4'b0000;
      end else if (w_dz) begin
        r_res   <= '1;
        r_long  <= bus.a;
        r_flags <= 4'b1010;
      end else if (w_ovf) begin
        r_res   <= MIN_NEG;
        r_long  <= '0;
        r_flags <= 4'b1001;
      end
    end else if (r_state == S_CALC) begin
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
      r_count <= r_count - 1'b1;
      if (r_count == CW'(1)) begin
        r_res   <= w_fres;
        r_long  <= w_flong;
        r_flags <= w_fflags;
      end
    end
  end

  assign bus.busy   = (r_state == S_CALC);
  assign bus.done   = (r_state == S_FIN);
  assign bus.Result = r_res;
  assign bus.Long   = r_long;
  assign bus.Flags  = r_flags;
endmodule
